mod_inverse: RTL
================

Name: mod_inverse

Overview:
- Computes the RSA private exponent d = e^-1 mod phi with the iterative extended Euclidean algorithm.
- Sits directly downstream of the gcd coprimality check in the key-generation path. It consumes the same (e, phi) pair and produces d for the decoder.
- Also re-derives gcd(e, phi) and flags when no inverse exists.
- Multi-cycle FSM with a start/done handshake; one restoring-division step per clock.

Parameters:
- W, 8, operand width in bits for e, phi and d.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- e  in  W  public exponent (unsigned).
- phi  in  W  modulus phi(n) (unsigned).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- valid  out  1  1 = inverse exists; held until the next accepted start.
- d  out  W  inverse in [1, phi-1] when valid=1, else 0; held until the next accepted start.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. rst forces state IDLE and busy=done=valid=0, d=0, including mid-operation; any in-flight computation is discarded.
- Registers:
  - r0 and r1 are unsigned W-bit.
  - t0 and t1 are signed W+2-bit.
  - q is W-bit.
  - Latched copy phi_l of phi.
- IDLE: wait for start. start=1 latches e and phi, sets busy=1, and goes to CHECK. start is ignored while busy.
- CHECK (1 cycle):
  - If phi_l < 2 or e == 0, go to FIN with the fail flag set.
  - Else set r0=phi_l, r1=e, t0=0, t1=1, and go to DIV.
  - e >= phi is legal; the first iteration reduces it.
- DIV (exactly W cycles): restoring division of r0 by r1, one quotient bit per cycle, MSB first. Produces q = r0 / r1 and rem = r0 mod r1.
- UPDATE (1 cycle):
  - (r0, r1) <= (r1, rem).
  - (t0, t1) <= (t1, t0 - q*t1), computed in signed 2W+2 bits and truncated to W+2. |t| <= phi is guaranteed, so no overflow.
  - If the new r1 == 0, go to FIX; else return to DIV.
- FIX (1 cycle):
  - If r0 == 1: d <= t0 if t0 >= 0, else t0 + phi_l (truncated to W bits); valid <= 1.
  - Else: d <= 0, valid <= 0.
- FIN (1 cycle): done=1 for exactly this cycle, busy=0 in the same cycle, then go to IDLE.
  - On the fail path (from CHECK), d=0 and valid=0.
- Latency: start to done = 1 (CHECK) + k*(W+1) + 2, where k is the number of Euclid iterations.
  - Worst case for W=8 is k <= 12, i.e. <= 111 cycles.
- A start asserted on the same cycle as done/FIN is ignored. It is accepted from IDLE one cycle later.
- d and valid are stable and unchanged from done until the next accepted start.

Optional Feature:
- MOD_INVERSE_GCD_OUT_EN defined: adds output port g (W bits).
  - g = the final r0 (gcd(e, phi)), registered in FIX alongside d.
  - g = 0 on reset and on the fail path.
  - Lets the upstream gcd stage be cross-checked or eliminated.
- Not defined: port g and its register are absent; all other behaviour is identical.

Test Plan:
- rst high 2 cycles, then e=7, phi=40, start pulse -> done within 111 cycles, valid=1, d=23; with MOD_INVERSE_GCD_OUT_EN, g=1.
- e=5, phi=192 -> valid=1, d=77. Then back-to-back e=3, phi=20 issued the cycle after done -> second result valid=1, d=7.
- e=6, phi=40 (not coprime) -> valid=0, d=0, g=2 when the macro is enabled. Also e=0, phi=40 -> done 2 cycles after start, valid=0, d=0.
- e=255, phi=254 (e > phi) -> valid=1, d=1. Also phi=1 -> valid=0 via the CHECK fail path.
- Start e=7, phi=40, then assert rst for 1 cycle mid-DIV -> busy=0, done never pulses, d=0, valid=0. A fresh start e=3, phi=20 then yields d=7.
- Pulse start again while busy with e=9 -> ignored; the original e=7, phi=40 still completes with d=23.

Source files
------------

// File: rtl/mod_inverse_if.sv
// Start/done bus for mod_inverse. The g port exists only when MOD_INVERSE_GCD_OUT_EN is defined.
interface mod_inverse_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] e;
  logic [W-1:0] phi;
  logic         busy;
  logic         done;
  logic         valid;
  logic [W-1:0] d;
`ifdef MOD_INVERSE_GCD_OUT_EN
  logic [W-1:0] g;

  modport master (output start, e, phi, input busy, done, valid, d, g);
  modport slave  (input start, e, phi, output busy, done, valid, d, g);
`else
  modport master (output start, e, phi, input busy, done, valid, d);
  modport slave  (input start, e, phi, output busy, done, valid, d);
`endif
endinterface

// File: rtl/mod_inverse.sv
// d = e^-1 mod phi by iterative extended Euclid, one restoring-division bit per clock.
// Optional gcd output g is enabled by defining MOD_INVERSE_GCD_OUT_EN.
module mod_inverse #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  mod_inverse_if.slave bus
);
  localparam int TW = W + 2;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, CHECK, DIV, UPDATE, FIX, FIN} state_t;

  state_t                 state, state_nx;
  logic [W-1:0]           r0, r1, q, rem, phi_l;
  logic signed [TW-1:0]   t0, t1;
  logic [CW-1:0]          cnt;
  logic [W-1:0]           d_r;
  logic                   valid_r;
`ifdef MOD_INVERSE_GCD_OUT_EN
  logic [W-1:0]           g_r;
`endif

  logic [W:0]             trial;
  logic                   take;
  logic [W-1:0]           rem_step;
  logic [TW-1:0]          t_next;
  logic [W-1:0]           d_fix;
  logic                   fail;

  always_comb begin
    trial    = {rem, q[W-1]};
    take     = trial >= {1'b0, r1};
    // true difference is < r1, so the low W bits are exact
    rem_step = trial[W-1:0] - r1;
    // low TW bits of t0 - q*t1 are the same whatever width it is formed in
    t_next   = t0 - {2'b00, q} * t1;
    d_fix    = t0[W-1:0] + (t0[TW-1] ? phi_l : '0);
    fail     = (phi_l < W'(2)) || (r1 == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CHECK;
      CHECK:   state_nx = fail ? FIN : DIV;
      DIV:     if (cnt == CW'(W - 1)) state_nx = UPDATE;
      UPDATE:  state_nx = (rem == '0) ? FIX : DIV;
      FIX:     state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0      <= '0;
      r1      <= '0;
      q       <= '0;
      rem     <= '0;
      phi_l   <= '0;
      t0      <= '0;
      t1      <= '0;
      cnt     <= '0;
      d_r     <= '0;
      valid_r <= 1'b0;
`ifdef MOD_INVERSE_GCD_OUT_EN
      g_r     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          r0      <= bus.phi;
          r1      <= bus.e;
          phi_l   <= bus.phi;
          d_r     <= '0;
          valid_r <= 1'b0;
`ifdef MOD_INVERSE_GCD_OUT_EN
          g_r     <= '0;
`endif
        end
        CHECK: begin
          t0  <= '0;
          t1  <= TW'(1);
          q   <= r0;
          rem <= '0;
          cnt <= '0;
        end
        DIV: begin
          q   <= {q[W-2:0], take};
          rem <= take ? rem_step : trial[W-1:0];
          cnt <= cnt + CW'(1);
        end
        UPDATE: begin
          r0  <= r1;
          r1  <= rem;
          t0  <= t1;
          t1  <= t_next;
          q   <= r1;
          rem <= '0;
          cnt <= '0;
        end
        FIX: begin
          if (r0 == W'(1)) begin
            d_r     <= d_fix;
            valid_r <= 1'b1;
          end else begin
            d_r     <= '0;
            valid_r <= 1'b0;
          end
`ifdef MOD_INVERSE_GCD_OUT_EN
          g_r <= r0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE) && (state != FIN);
  assign bus.done  = (state == FIN);
  assign bus.valid = valid_r;
  assign bus.d     = d_r;
`ifdef MOD_INVERSE_GCD_OUT_EN
  assign bus.g     = g_r;
`endif
endmodule
